// File: rtl/uart_brg_nco.sv
// Fractional-N baud rate generator: phase accumulator NCO producing oversample
// enables, bit-boundary and mid-bit ticks from a table or programmable increment.
module uart_brg_nco #(
  parameter  int unsigned CLKFRQ     = 50000000,
  parameter  int unsigned OVERSAMPLE = 16,
  parameter  int unsigned ACCW       = 32,
  localparam int unsigned PHW        = $clog2(OVERSAMPLE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      speed,
  input  logic            mode,
  input  logic            incr_wr,
  input  logic [ACCW-1:0] incr_in,
  input  logic            enable,
  input  logic            resync,
  output logic            clken,
  output logic            bitclk,
  output logic            midbit,
  output logic [PHW-1:0]  phase,
  output logic [ACCW-1:0] incr_out
);

  localparam int unsigned KEYW = 6;

  function automatic real rate_of(int code);
    case (code)
      0:       return 50.0;
      1:       return 75.0;
      2:       return 110.0;
      3:       return 134.5;
      4:       return 150.0;
      5:       return 300.0;
      6:       return 600.0;
      7:       return 1200.0;
      8:       return 1800.0;
      9:       return 2000.0;
      10:      return 2400.0;
      11:      return 3600.0;
      12:      return 4800.0;
      13:      return 7200.0;
      14:      return 9600.0;
      15:      return 19200.0;
      16:      return 38400.0;
      17:      return 57600.0;
      18:      return 115200.0;
      19:      return 230400.0;
      20:      return 460800.0;
      21:      return 921600.0;
      default: return 9600.0;
    endcase
  endfunction

  // Round to nearest, then wrap modulo 2^ACCW before narrowing.
  function automatic logic [ACCW-1:0] rate_incr(real baud);
    real full;
    real x;
    full = 2.0 ** ACCW;
    x    = $floor(full * real'(OVERSAMPLE) * baud / real'(CLKFRQ) + 0.5);
    x    = x - $floor(x / full) * full;
    return ACCW'(longint'(x));
  endfunction

  logic [ACCW-1:0] rate_tbl [32];

  for (genvar g = 0; g < 32; g++) begin : g_tbl
    localparam logic [ACCW-1:0] INC = rate_incr(rate_of(g));
    assign rate_tbl[g] = INC;
  end

  logic [ACCW-1:0] prog_incr_q;
  logic [ACCW-1:0] act_incr_q;
  logic [ACCW-1:0] accum_q, accum_d;
  logic            carry_q, carry_d;
  logic [PHW-1:0]  phase_q, phase_d;
  logic [KEYW-1:0] key_q;
  logic [KEYW-1:0] key_c;
  logic            restart_c;
  logic [ACCW:0]   sum_c;

  assign key_c     = {mode, speed};
  assign restart_c = resync | (key_c != key_q) | (incr_wr & mode);

  // Restart beats enable; the phase follows every emitted clken pulse.
  always_comb begin
    sum_c   = {1'b0, accum_q} + {1'b0, act_incr_q};
    accum_d = accum_q;
    carry_d = 1'b0;
    phase_d = phase_q;
    if (restart_c) begin
      accum_d = '0;
      phase_d = '0;
    end else begin
      if (enable) begin
        accum_d = sum_c[ACCW-1:0];
        carry_d = sum_c[ACCW];
      end
      if (carry_q) begin
        phase_d = phase_q + PHW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_incr_q <= '0;
      act_incr_q  <= '0;
      accum_q     <= '0;
      carry_q     <= 1'b0;
      phase_q     <= '0;
      key_q       <= '0;
    end else begin
      if (incr_wr) begin
        prog_incr_q <= incr_in;
      end
      act_incr_q <= mode ? prog_incr_q : rate_tbl[speed];
      key_q      <= key_c;
      accum_q    <= accum_d;
      carry_q    <= carry_d;
      phase_q    <= phase_d;
    end
  end

  assign clken    = carry_q;
  assign bitclk   = carry_q & (phase_q == PHW'(OVERSAMPLE - 1));
  assign midbit   = carry_q & (phase_q == PHW'(OVERSAMPLE / 2 - 1));
  assign phase    = phase_q;
  assign incr_out = act_incr_q;

endmodule

// File: tb/tb_uart_brg_nco.sv
// Bench for uart_brg_nco: outputs are predicted from the closed-form count of
// accumulator overflows, floor(j*incr/2^32) after j accumulation steps.
module tb_uart_brg_nco;

  typedef longint unsigned u64_t;

  localparam int ACCW = 32;
  localparam int OS   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      speed;
  logic            mode;
  logic            incr_wr;
  logic [ACCW-1:0] incr_in;
  logic            enable;
  logic            resync;
  logic            clken;
  logic            bitclk;
  logic            midbit;
  logic [3:0]      phase;
  logic [ACCW-1:0] incr_out;

  int n_checks = 0;
  int n_errors = 0;

  uart_brg_nco dut (
    .clk      (clk),
    .rst      (rst),
    .speed    (speed),
    .mode     (mode),
    .incr_wr  (incr_wr),
    .incr_in  (incr_in),
    .enable   (enable),
    .resync   (resync),
    .clken    (clken),
    .bitclk   (bitclk),
    .midbit   (midbit),
    .phase    (phase),
    .incr_out (incr_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic real rate_of(int code);
    case (code)
      0: return 50.0;       1: return 75.0;       2: return 110.0;     3: return 134.5;
      4: return 150.0;      5: return 300.0;      6: return 600.0;     7: return 1200.0;
      8: return 1800.0;     9: return 2000.0;     10: return 2400.0;   11: return 3600.0;
      12: return 4800.0;    13: return 7200.0;    14: return 9600.0;   15: return 19200.0;
      16: return 38400.0;   17: return 57600.0;   18: return 115200.0; 19: return 230400.0;
      20: return 460800.0;  21: return 921600.0;
      default: return 9600.0;
    endcase
  endfunction

  function automatic u64_t tbl(int code);
    return u64_t'($floor(4294967296.0 * 16.0 * rate_of(code) / 50000000.0 + 0.5));
  endfunction

  function automatic u64_t carries(u64_t incr, int j);
    return (u64_t'(j) * incr) >> ACCW;
  endfunction

  function automatic int exp_clken(u64_t incr, int j);
    if (j == 0) return 0;
    return int'(carries(incr, j) - carries(incr, j - 1));
  endfunction

  function automatic int exp_phase(u64_t incr, int j);
    if (j == 0) return 0;
    return int'(carries(incr, j - 1) % u64_t'(OS));
  endfunction

  // First step index >= from with the given phase (and clken value if ck >= 0).
  function automatic int find_j(u64_t incr, int from, int ph, int ck);
    for (int j = from; j < from + 100000; j++)
      if (exp_phase(incr, j) == ph && (ck < 0 || exp_clken(incr, j) == ck)) return j;
    return from;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_at(input u64_t incr, input int j, input string tag);
    int c;
    int p;
    c = exp_clken(incr, j);
    p = exp_phase(incr, j);
    check_eq({tag, ".clken"},  64'(clken),  64'(c));
    check_eq({tag, ".bitclk"}, 64'(bitclk), 64'(c == 1 && p == OS - 1));
    check_eq({tag, ".midbit"}, 64'(midbit), 64'(c == 1 && p == OS / 2 - 1));
    check_eq({tag, ".phase"},  64'(phase),  64'(p));
  endtask

  task automatic run_check(input u64_t incr, input int j_first, input int n,
                           input string tag, output int ncl);
    ncl = 0;
    for (int j = j_first; j < j_first + n; j++) begin
      step();
      sample_at(incr, j, tag);
      if (clken) ncl++;
    end
  endtask

  initial begin
    u64_t prog_r;
    u64_t cur_incr;
    u64_t x_incr;
    int   n;
    int   cur_code;
    int   code;
    int   j0;
    int   j1;
    int   jc;

    rst = 1'b1; speed = 5'd14; mode = 1'b0; incr_wr = 1'b0;
    incr_in = '0; enable = 1'b1; resync = 1'b0;
    repeat (3) step();
    check_eq("rst.clken",  64'(clken),    64'd0);
    check_eq("rst.bitclk", 64'(bitclk),   64'd0);
    check_eq("rst.midbit", 64'(midbit),   64'd0);
    check_eq("rst.phase",  64'(phase),    64'd0);
    check_eq("rst.incr",   64'(incr_out), 64'd0);

    // Table 9600 baud from reset, with a programmable write that must not disturb it
    rst = 1'b0;
    step();
    check_eq("b.incr", 64'(incr_out), 64'd13194140);
    sample_at(tbl(14), 0, "b");
    run_check(tbl(14), 1, 5000, "b", n);
    check_eq("b.count", 64'(n), carries(tbl(14), 5000));
    prog_r  = u64_t'($urandom | 32'h0100_0000);
    incr_in = ACCW'(prog_r);
    incr_wr = 1'b1;
    step();
    incr_wr = 1'b0;
    sample_at(tbl(14), 5001, "b.wr");
    run_check(tbl(14), 5002, 4999, "b2", n);
    check_eq("b.incr_hold", 64'(incr_out), 64'd13194140);

    // Speed change restarts the bit and loads the new increment one clock later
    speed = 5'd18;
    step();
    check_eq("c.incr", 64'(incr_out), 64'd158329674);
    sample_at(tbl(18), 0, "c");
    run_check(tbl(18), 1, 10000, "c", n);
    check_eq("c.count", 64'(n), carries(tbl(18), 10000));

    // Random speed codes and resync strobes
    cur_code = 18;
    cur_incr = tbl(18);
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        resync = 1'b1;
        step();
        resync = 1'b0;
      end else begin
        code = cur_code;
        while (code == cur_code) code = int'($urandom_range(0, 31));
        cur_code = code;
        cur_incr = tbl(code);
        speed = 5'(code);
        step();
        check_eq("d.incr", 64'(incr_out), cur_incr);
      end
      sample_at(cur_incr, 0, "d");
      run_check(cur_incr, 1, int'($urandom_range(300, 2000)), "d", n);
    end

    // Programmable mode uses the value written earlier in table mode
    mode = 1'b1;
    step();
    check_eq("e.incr", 64'(incr_out), prog_r);
    sample_at(prog_r, 0, "e");
    run_check(prog_r, 1, 500, "e", n);

    // Zero increment: no pulses at all
    incr_in = '0;
    incr_wr = 1'b1;
    step();
    incr_wr = 1'b0;
    sample_at(0, 0, "f");
    run_check(0, 1, 10000, "f", n);
    check_eq("f.count", 64'(n), 64'd0);
    check_eq("f.incr", 64'(incr_out), 64'd0);

    // Half-rate increment: prog -> act -> accum latency, then resync at phase 9
    x_incr  = 64'h8000_0000;
    incr_in = ACCW'(x_incr);
    incr_wr = 1'b1;
    step();
    incr_wr = 1'b0;
    check_eq("g.incr_lat", 64'(incr_out), 64'd0);
    sample_at(0, 0, "g.e0");
    step();
    check_eq("g.incr", 64'(incr_out), x_incr);
    sample_at(x_incr, 0, "g");
    j1 = find_j(x_incr, 100, 9, -1);
    run_check(x_incr, 1, j1, "g", n);
    check_eq("g.count", 64'(n), carries(x_incr, j1));
    resync = 1'b1;
    step();
    resync = 1'b0;
    sample_at(x_incr, 0, "g.rs");
    run_check(x_incr, 1, 100, "g.rs", n);

    // Freeze at phase 5, then resume from the held accumulator
    j0 = find_j(x_incr, 101, 5, 0);
    run_check(x_incr, 101, j0 - 100, "h", n);
    enable = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      check_eq("h.off.clken",  64'(clken),  64'd0);
      check_eq("h.off.bitclk", 64'(bitclk), 64'd0);
      check_eq("h.off.midbit", 64'(midbit), 64'd0);
      check_eq("h.off.phase",  64'(phase),  64'd5);
    end
    enable = 1'b1;
    run_check(x_incr, j0 + 1, 100, "h.re", n);

    // Asynchronous reset in the middle of a clken pulse
    jc = j0 + 101;
    while (exp_clken(x_incr, jc) != 1) jc++;
    run_check(x_incr, j0 + 101, jc - j0 - 100, "i", n);
    rst = 1'b1;
    #1;
    check_eq("i.rst.clken",  64'(clken),    64'd0);
    check_eq("i.rst.bitclk", 64'(bitclk),   64'd0);
    check_eq("i.rst.midbit", 64'(midbit),   64'd0);
    check_eq("i.rst.phase",  64'(phase),    64'd0);
    check_eq("i.rst.incr",   64'(incr_out), 64'd0);
    step();
    step();
    mode  = 1'b0;
    speed = 5'd14;
    rst   = 1'b0;
    step();
    check_eq("i.incr", 64'(incr_out), 64'd13194140);
    sample_at(tbl(14), 0, "i.tbl");
    run_check(tbl(14), 1, 2000, "i.tbl", n);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
